// File: rtl/serial_cmd_master.sv
// Host-side initiator for the trigger board command protocol: sends opcode and
// arguments through a UART transmitter, then collects the reply with a silence timeout.
module serial_cmd_master #(
  parameter int MAXARGS  = 8,
  parameter int MAXREPLY = 32,
  parameter int TIMEOUT  = 5000000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [7:0]            cmd_op,
  input  logic [3:0]            cmd_nargs,
  input  logic [8*MAXARGS-1:0]  cmd_args,
  input  logic [5:0]            cmd_nreply,
  input  logic                  txBusy,
  output logic                  txStart,
  output logic [7:0]            txData,
  input  logic                  rxReady,
  input  logic [7:0]            rxData,
  output logic                  rsp_valid,
  output logic [8*MAXREPLY-1:0] rsp_data,
  output logic [5:0]            rsp_count,
  output logic                  rsp_timeout,
  output logic [7:0]            rx_dropped,
  output logic                  busy
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [3:0]    MAXARGS_C  = 4'(MAXARGS);
  localparam logic [5:0]    MAXREPLY_C = 6'(MAXREPLY);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_ONE    = TW'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND      = 3'd1,
    SEND_WAIT = 3'd2,
    RECV      = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t               state_r;
  logic [7:0]           op_r;
  logic [8*MAXARGS-1:0] args_r;
  logic [3:0]           nargs_r;
  logic [3:0]           idx_r;
  logic [5:0]           nreply_r;
  logic [TW-1:0]        tmo_r;
  logic [3:0]           nargs_clamp_s;
  logic [5:0]           nreply_clamp_s;

  assign nargs_clamp_s  = (cmd_nargs > MAXARGS_C) ? MAXARGS_C : cmd_nargs;
  assign nreply_clamp_s = (cmd_nreply > MAXREPLY_C) ? MAXREPLY_C : cmd_nreply;
  assign cmd_ready      = (state_r == IDLE) && reset_n;
  assign busy           = (state_r != IDLE);

  // Wire byte 0 is the opcode, byte k is argument k-1.
  function automatic logic [7:0] tx_byte(input logic [7:0] op,
                                         input logic [8*MAXARGS-1:0] args,
                                         input logic [3:0] idx);
    logic [7:0] b;
    b = op;
    for (int k = 0; k < MAXARGS; k++) begin
      if (idx == 4'(k + 1)) b = args[8*k +: 8];
    end
    return b;
  endfunction

  // Command sequencer: send phase, reply collection, completion pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      op_r        <= 8'd0;
      args_r      <= {(8*MAXARGS){1'b0}};
      nargs_r     <= 4'd0;
      idx_r       <= 4'd0;
      nreply_r    <= 6'd0;
      tmo_r       <= {TW{1'b0}};
      txStart     <= 1'b0;
      txData      <= 8'd0;
      rsp_valid   <= 1'b0;
      rsp_data    <= {(8*MAXREPLY){1'b0}};
      rsp_count   <= 6'd0;
      rsp_timeout <= 1'b0;
    end else begin
      txStart   <= 1'b0;
      rsp_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            op_r        <= cmd_op;
            args_r      <= cmd_args;
            nargs_r     <= nargs_clamp_s;
            nreply_r    <= nreply_clamp_s;
            idx_r       <= 4'd0;
            rsp_data    <= {(8*MAXREPLY){1'b0}};
            rsp_count   <= 6'd0;
            rsp_timeout <= 1'b0;
            state_r     <= SEND;
          end
        end
        SEND: begin
          if (!txBusy) begin
            txData  <= tx_byte(op_r, args_r, idx_r);
            txStart <= 1'b1;
            state_r <= SEND_WAIT;
          end
        end
        SEND_WAIT: begin
          // One spare cycle lets the UART raise txBusy before the next byte.
          if (idx_r < nargs_r) begin
            idx_r   <= idx_r + 4'd1;
            state_r <= SEND;
          end else if (nreply_r == 6'd0) begin
            rsp_valid <= 1'b1;
            state_r   <= DONE;
          end else begin
            tmo_r   <= {TW{1'b0}};
            state_r <= RECV;
          end
        end
        RECV: begin
          if (rxReady) begin
            for (int i = 0; i < MAXREPLY; i++) begin
              if (rsp_count == 6'(i)) rsp_data[8*i +: 8] <= rxData;
            end
            rsp_count <= rsp_count + 6'd1;
            tmo_r     <= {TW{1'b0}};
            if (rsp_count + 6'd1 == nreply_r) begin
              rsp_valid <= 1'b1;
              state_r   <= DONE;
            end
          end else if (tmo_r == TMO_LAST) begin
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            state_r     <= DONE;
          end else begin
            tmo_r <= tmo_r + TMO_ONE;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Saturating count of reply bytes that arrive while no reply is being collected.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_dropped <= 8'd0;
    end else if (rxReady && (state_r != RECV) && (rx_dropped != 8'hFF)) begin
      rx_dropped <= rx_dropped + 8'd1;
    end
  end

endmodule

// File: tb/tb_serial_cmd_master.sv
// Randomised bench for serial_cmd_master: a queue/array model of the command
// protocol predicts transmitted bytes, reply contents, timing and drop counts.
module tb_serial_cmd_master;

  localparam int TMO = 40;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [7:0]   cmd_op;
  logic [3:0]   cmd_nargs;
  logic [63:0]  cmd_args;
  logic [5:0]   cmd_nreply;
  logic         txBusy;
  logic         txStart;
  logic [7:0]   txData;
  logic         rxReady;
  logic [7:0]   rxData;
  logic         rsp_valid;
  logic [255:0] rsp_data;
  logic [5:0]   rsp_count;
  logic         rsp_timeout;
  logic [7:0]   rx_dropped;
  logic         busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int exp_drop = 0;

  logic hold_busy  = 1'b0;
  logic model_busy = 1'b0;
  int   busy_left  = 0;

  int           seen;
  int           rv_cyc;
  logic [255:0] snap_data;
  logic [5:0]   snap_count;
  logic         snap_to;

  assign txBusy = hold_busy | model_busy;

  serial_cmd_master #(.MAXARGS(8), .MAXREPLY(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_nargs(cmd_nargs), .cmd_args(cmd_args), .cmd_nreply(cmd_nreply),
    .txBusy(txBusy), .txStart(txStart), .txData(txData),
    .rxReady(rxReady), .rxData(rxData),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_count(rsp_count),
    .rsp_timeout(rsp_timeout), .rx_dropped(rx_dropped), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // UART transmitter stand-in: busy from the cycle after each start, random length.
  always @(negedge clk) begin
    if (txStart === 1'b1) busy_left = $urandom_range(1, 4);
    if (busy_left > 0) begin
      model_busy = 1'b1;
      busy_left--;
    end else begin
      model_busy = 1'b0;
    end
  end

  task automatic step_watch();
    @(negedge clk);
    if (rsp_valid === 1'b1) begin
      seen++;
      rv_cyc     = cyc;
      snap_data  = rsp_data;
      snap_count = rsp_count;
      snap_to    = rsp_timeout;
    end
  endtask

  task automatic run_cmd(input logic [7:0] op, input logic [3:0] nargs, input logic [63:0] args,
                         input logic [5:0] nreply, input int reply_len, input logic [319:0] reply,
                         input int hold, input bit gaps, input bit chk_lat, input string name);
    byte unsigned exp_tx[$];
    byte unsigned got_tx[$];
    int ne, nr, stored, acc_cyc, first_tx, last_tx, last_rx, want, b;
    bit exp_to, tx_ok, hold_ok;
    logic [255:0] exp_data;
    ne     = (nargs > 4'd8) ? 8 : int'(nargs);
    nr     = (nreply > 6'd32) ? 32 : int'(nreply);
    stored = (reply_len < nr) ? reply_len : nr;
    exp_to = (reply_len < nr);
    exp_tx.push_back(op);
    for (int k = 0; k < ne; k++) exp_tx.push_back(args[8*k +: 8]);
    exp_data = '0;
    for (int k = 0; k < stored; k++) exp_data[8*k +: 8] = reply[8*k +: 8];
    if (reply_len > nr) exp_drop = (exp_drop + reply_len - nr > 255) ? 255 : exp_drop + reply_len - nr;

    b = 0;
    while (cmd_ready !== 1'b1 && b < 50) begin @(negedge clk); b++; end
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL %s ready_wait: cmd_ready=%b, want 1", name, cmd_ready); end

    cmd_valid = 1'b1; cmd_op = op; cmd_nargs = nargs; cmd_args = args; cmd_nreply = nreply;
    acc_cyc = cyc;
    if (hold > 0) hold_busy = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    hold_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      if (txStart !== 1'b0) hold_ok = 1'b0;
      if (i == 3) begin cmd_valid = 1'b1; cmd_op = 8'h55; cmd_nargs = 4'd0; cmd_nreply = 6'd0; end
      if (i == 4) cmd_valid = 1'b0;
      @(negedge clk);
    end
    if (hold > 0) begin
      hold_busy = 1'b0;
      total++;
      if (hold_ok !== 1'b1) begin bad++; $display("FAIL %s hold_no_start: txStart seen while txBusy held, want none", name); end
    end

    first_tx = -1; last_tx = -1;
    for (int i = 0; i < 400 && got_tx.size() < ne + 1; i++) begin
      if (txStart === 1'b1) begin
        got_tx.push_back(txData);
        if (first_tx < 0) first_tx = cyc;
        last_tx = cyc;
      end
      if (got_tx.size() < ne + 1) @(negedge clk);
    end
    tx_ok = (got_tx.size() == exp_tx.size());
    for (int i = 0; i < got_tx.size() && tx_ok; i++) if (got_tx[i] != exp_tx[i]) tx_ok = 1'b0;
    total++;
    if (tx_ok !== 1'b1) begin bad++; $display("FAIL %s tx_bytes: got %p want %p", name, got_tx, exp_tx); end
    if (chk_lat) begin
      total++;
      if (first_tx !== acc_cyc + 2) begin bad++; $display("FAIL %s start_latency: first txStart at %0d want %0d", name, first_tx, acc_cyc + 2); end
    end

    seen = 0; rv_cyc = -1; last_rx = last_tx;
    if (nr > 0) begin
      step_watch();
      for (int k = 0; k < reply_len; k++) begin
        if (gaps) repeat ($urandom_range(0, 2)) step_watch();
        rxReady = 1'b1; rxData = reply[8*k +: 8];
        if (k < nr) last_rx = cyc;
        step_watch();
        rxReady = 1'b0;
      end
    end
    for (int i = 0; i < TMO + 20 && seen == 0; i++) step_watch();

    total++;
    if (seen !== 1) begin bad++; $display("FAIL %s rsp_pulses: got %0d want 1", name, seen); end
    want = -1;
    if (!exp_to) want = last_rx + 1;
    else if (reply_len > 0) want = last_rx + TMO + 1;
    if (want >= 0) begin
      total++;
      if (rv_cyc !== want) begin bad++; $display("FAIL %s rsp_time: rsp_valid at %0d want %0d", name, rv_cyc, want); end
    end
    total++;
    if (snap_count !== 6'(stored)) begin bad++; $display("FAIL %s rsp_count: got %0d want %0d", name, snap_count, stored); end
    total++;
    if (snap_data !== exp_data) begin bad++; $display("FAIL %s rsp_data: got %h want %h", name, snap_data, exp_data); end
    total++;
    if (snap_to !== exp_to) begin bad++; $display("FAIL %s rsp_timeout: got %b want %b", name, snap_to, exp_to); end
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL %s rsp_end: rsp_valid=%b cmd_ready=%b want 0/1", name, rsp_valid, cmd_ready);
    end
    total++;
    if (rx_dropped !== 8'(exp_drop)) begin bad++; $display("FAIL %s rx_dropped: got %0d want %0d", name, rx_dropped, exp_drop); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 8'd0; cmd_nargs = 4'd0; cmd_args = 64'd0;
    cmd_nreply = 6'd0; rxReady = 1'b0; rxData = 8'd0;
    repeat (3) @(negedge clk);
    total++;
    if (cmd_ready !== 1'b0 || busy !== 1'b0 || txStart !== 1'b0 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl: ready=%b busy=%b txStart=%b rsp_valid=%b want all 0", cmd_ready, busy, txStart, rsp_valid);
    end
    total++;
    if (rsp_count !== 6'd0 || rsp_timeout !== 1'b0 || rx_dropped !== 8'd0 || txData !== 8'd0 || rsp_data !== '0) begin
      bad++; $display("FAIL reset_data: count=%0d to=%b drop=%0d txData=%h data=%h want 0", rsp_count, rsp_timeout, rx_dropped, txData, rsp_data);
    end
    reset_n = 1'b1;
    exp_drop = 0;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_release: cmd_ready=%b want 1", cmd_ready); end
  endtask

  task automatic test_basic();
    logic [319:0] r;
    r = '0; r[7:0] = 8'h08;
    run_cmd(8'h00, 4'd0, 64'd0, 6'd1, 1, r, 0, 1'b0, 1'b1, "basic");
  endtask

  task automatic test_args();
    run_cmd(8'h0E, 4'd8, 64'h0807060504030201, 6'd0, 0, 320'd0, 0, 1'b0, 1'b0, "args8");
  endtask

  task automatic test_back_to_back();
    logic [319:0] r;
    r = '0;
    for (int k = 0; k < 33; k++) r[8*k +: 8] = 8'(k);
    run_cmd(8'h0A, 4'd0, 64'd0, 6'd32, 33, r, 0, 1'b0, 1'b0, "b2b32");
  endtask

  task automatic test_timeout();
    logic [319:0] r;
    r = '0; r[23:0] = 24'hA3A2A1;
    run_cmd(8'h10, 4'd0, 64'd0, 6'd8, 3, r, 0, 1'b0, 1'b0, "timeout");
  endtask

  task automatic test_busy_hold();
    logic [319:0] r;
    r = '0; r[7:0] = 8'h5A;
    run_cmd(8'h21, 4'd2, 64'h000000000000BEEF, 6'd1, 1, r, 100, 1'b0, 1'b0, "busyhold");
  endtask

  task automatic test_random();
    logic [7:0] op; logic [3:0] na; logic [63:0] ar; logic [5:0] nrq; logic [319:0] r;
    int nr, rl;
    for (int t = 0; t < 15; t++) begin
      op  = 8'($urandom);
      na  = 4'($urandom);
      ar  = {$urandom(), $urandom()};
      nrq = 6'($urandom_range(0, 40));
      nr  = (nrq > 6'd32) ? 32 : int'(nrq);
      r   = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      if (nr == 0) rl = 0;
      else if ($urandom_range(0, 3) == 0) rl = $urandom_range(0, nr - 1);
      else rl = nr + $urandom_range(0, 2);
      run_cmd(op, na, ar, nrq, rl, r, 0, 1'b1, 1'b0, "rand");
    end
  endtask

  task automatic test_stray();
    for (int i = 0; i < 300; i++) begin
      rxReady = 1'b1; rxData = 8'($urandom);
      @(negedge clk);
    end
    rxReady = 1'b0;
    exp_drop = (exp_drop + 300 > 255) ? 255 : exp_drop + 300;
    @(negedge clk);
    total++;
    if (rx_dropped !== 8'(exp_drop) || busy !== 1'b0) begin
      bad++; $display("FAIL stray: rx_dropped=%0d busy=%b want %0d/0", rx_dropped, busy, exp_drop);
    end
  endtask

  task automatic test_reset_mid();
    int b;
    bit pulse;
    cmd_valid = 1'b1; cmd_op = 8'h30; cmd_nargs = 4'd0; cmd_nreply = 6'd8;
    @(negedge clk);
    cmd_valid = 1'b0;
    b = 0;
    while (txStart !== 1'b1 && b < 50) begin @(negedge clk); b++; end
    total++;
    if (txStart !== 1'b1) begin bad++; $display("FAIL rstmid start: txStart=%b want 1", txStart); end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      rxReady = 1'b1; rxData = 8'hC0 + 8'(k);
      @(negedge clk);
    end
    rxReady = 1'b0;
    total++;
    if (rsp_count !== 6'd2 || busy !== 1'b1) begin bad++; $display("FAIL rstmid partial: count=%0d busy=%b want 2/1", rsp_count, busy); end
    reset_n = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || cmd_ready !== 1'b0 || txStart !== 1'b0 || rsp_valid !== 1'b0 || txData !== 8'd0) begin
      bad++; $display("FAIL rstmid ctrl: busy=%b ready=%b txStart=%b rsp_valid=%b txData=%h want 0", busy, cmd_ready, txStart, rsp_valid, txData);
    end
    total++;
    if (rsp_count !== 6'd0 || rsp_data !== '0 || rsp_timeout !== 1'b0 || rx_dropped !== 8'd0) begin
      bad++; $display("FAIL rstmid data: count=%0d to=%b drop=%0d data=%h want 0", rsp_count, rsp_timeout, rx_dropped, rsp_data);
    end
    reset_n = 1'b1;
    exp_drop = 0;
    pulse = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || busy !== 1'b0) pulse = 1'b1;
    end
    total++;
    if (pulse !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL rstmid after: stray activity=%b cmd_ready=%b want 0/1", pulse, cmd_ready);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_args();
    test_back_to_back();
    test_timeout();
    test_busy_hold();
    test_random();
    test_stray();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
